instr_fetch: RTL

- Upstream stage of the instruction decoder/controller.
- Reads two consecutive 16-bit words from the program ROM and assembles them into the 32-bit control word.
  - Low word carries opvar/opcode/operands/results; high word carries the immediate/address.
- Presents the word with a valid/advance handshake and accepts PC redirects for jumps.
- Sits between the program ROM port and the control unit's controlWord input.

---
 rtl/instr_fetch.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/instr_fetch.sv
// instr_fetch: reads two 16-bit ROM words per instruction and presents the 32-bit control word.
// Define INSTR_FETCH_PREFETCH_EN to add a shadow buffer that prefetches the next instruction.
module instr_fetch #(
   parameter int          ROM_LATENCY = 1,
   parameter logic [15:0] BASE_ADDR   = 16'h0000,
   parameter logic [15:0] RESET_PC    = 16'h0000
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [15:0] pcIn,
   input  logic        pcLoad,
   input  logic        advance,
   output logic [15:0] romAddr,
   output logic        romRead,
   input  logic [15:0] romData,
   output logic [31:0] controlWord,
   output logic        wordValid,
   output logic [15:0] fetchPc
);

   typedef enum logic [2:0] {S_IDLE, S_REQ_LO, S_REQ_HI, S_WAIT, S_FULL} state_t;

   typedef struct packed {
      logic valid;
      logic hi;
      logic epoch;
   } trk_t;

   localparam int LAT = ROM_LATENCY;

   state_t      state, state_nxt;
   trk_t        trk [LAT];
   trk_t        resp;
   logic        epoch;
   logic [15:0] req_idx, lo_addr, lo_buf, pf_step;
   logic        lo_got;
   logic        ld, adv, refill, resp_ok, lo_hit, done;
   logic [31:0] full_word;

`ifdef INSTR_FETCH_PREFETCH_EN
   logic [31:0] shadow;
   logic        shadow_valid;

   assign refill  = !shadow_valid;
   assign pf_step = (adv && shadow_valid) ? 16'd2 : 16'd1;
`else
   assign refill  = 1'b0;
   assign pf_step = 16'd1;
`endif

   assign ld        = pcLoad && (state != S_IDLE);
   assign adv       = advance && wordValid && !ld;
   assign resp      = trk[LAT-1];
   // A response counts only if it belongs to the current epoch and a fetch is expecting it.
   assign resp_ok   = resp.valid && (resp.epoch == epoch) && !ld;
   assign lo_hit    = resp_ok && !resp.hi && (state == S_REQ_HI || state == S_WAIT);
   assign done      = resp_ok && resp.hi && lo_got && (state == S_WAIT);
   assign full_word = {romData, lo_buf};
   assign lo_addr   = BASE_ADDR + (req_idx << 1);

   // NOTE: state and datapath registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   state_nxt = S_REQ_LO;
         S_REQ_LO: state_nxt = S_REQ_HI;
         S_REQ_HI: state_nxt = S_WAIT;
         S_WAIT:   if (done) state_nxt = S_FULL;
         S_FULL:   if (adv || refill) state_nxt = S_REQ_LO;
         default:  state_nxt = S_IDLE;
      endcase
      if (ld) state_nxt = S_REQ_LO;
   end

   // NOTE: every output gets a default before the case so no latch is inferred.
   always_comb begin
      romRead = 1'b0;
      romAddr = '0;
      case (state)
         S_REQ_LO: begin
            romRead = 1'b1;
            romAddr = lo_addr;
         end
         S_REQ_HI: begin
            romRead = !pcLoad;
            romAddr = lo_addr + 16'd1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         // NOTE: the tracker is reset because its valid bits gate data capture; lo_buf is reset only for tidiness.
         for (int i = 0; i < LAT; i++) trk[i] <= '0;
         epoch       <= 1'b0;
         req_idx     <= RESET_PC;
         lo_buf      <= '0;
         lo_got      <= 1'b0;
         fetchPc     <= RESET_PC;
         controlWord <= '0;
         wordValid   <= 1'b0;
`ifdef INSTR_FETCH_PREFETCH_EN
         shadow       <= '0;
         shadow_valid <= 1'b0;
`endif
      end else begin
         trk[0] <= '{valid: romRead, hi: (state == S_REQ_HI), epoch: epoch};
         for (int i = 1; i < LAT; i++) trk[i] <= trk[i-1];

         if (ld) epoch <= ~epoch;

         if (ld)                                          req_idx <= pcIn;
         else if (state == S_FULL && state_nxt == S_REQ_LO) req_idx <= fetchPc + pf_step;

         if (lo_hit) begin
            lo_buf <= romData;
            lo_got <= 1'b1;
         end
         if (state_nxt == S_REQ_LO) lo_got <= 1'b0;

`ifdef INSTR_FETCH_PREFETCH_EN
         if (ld) begin
            fetchPc      <= pcIn;
            wordValid    <= 1'b0;
            shadow_valid <= 1'b0;
         end else if (adv) begin
            fetchPc <= fetchPc + 16'd1;
            if (shadow_valid) begin
               controlWord  <= shadow;
               shadow_valid <= 1'b0;
            end else if (done) begin
               controlWord <= full_word;
            end else begin
               wordValid <= 1'b0;
            end
         end else if (done) begin
            if (wordValid) begin
               shadow       <= full_word;
               shadow_valid <= 1'b1;
            end else begin
               controlWord <= full_word;
               wordValid   <= 1'b1;
            end
         end
`else
         if (ld) begin
            fetchPc   <= pcIn;
            wordValid <= 1'b0;
         end else if (adv) begin
            fetchPc   <= fetchPc + 16'd1;
            wordValid <= 1'b0;
         end else if (done) begin
            controlWord <= full_word;
            wordValid   <= 1'b1;
         end
`endif
      end
   end

endmodule
